// File: rtl/adc_wave_meter_if.sv
// Signal bundle between the ADC capture side and the wave meter.
// The master drives samples and receives results; the meter is the slave.
interface adc_wave_meter_if;
  logic        adc_valid;
  logic [7:0]  adc_data;
  logic [31:0] freq_cnt;
  logic [7:0]  v_max;
  logic [7:0]  v_min;
  logic [7:0]  vpp;
  logic        no_signal;
  logic        meas_valid;

  modport master (
    output adc_valid, adc_data,
    input  freq_cnt, v_max, v_min, vpp, no_signal, meas_valid
  );

  modport slave (
    input  adc_valid, adc_data,
    output freq_cnt, v_max, v_min, vpp, no_signal, meas_valid
  );
endinterface

// File: rtl/adc_wave_meter.sv
// Gate-window frequency and amplitude meter for 8-bit unsigned ADC samples.
// Counts hysteretic rising mid-level crossings and tracks min/max/Vpp per window.
module adc_wave_meter #(
  parameter int unsigned GATE_CYCLES = 50_000_000,
  parameter logic [7:0]  MID         = 8'd128,
  parameter logic [7:0]  HYST        = 8'd8
) (
  input  logic             sys_clk,
  input  logic             sys_rst,
  adc_wave_meter_if.slave  bus
);

  localparam int unsigned       GATE_W    = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
  localparam logic [7:0]        THR_LO    = MID - HYST;
  localparam logic [7:0]        THR_HI    = MID + HYST;

  typedef enum logic {
    ARM_LOW   = 1'b0,
    WAIT_HIGH = 1'b1
  } det_state_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  function automatic logic [7:0] span(input logic [7:0] hi, input logic [7:0] lo);
    return hi - lo;
  endfunction

  det_state_t        state;
  logic [GATE_W-1:0] gate_cnt;

  logic [31:0] edge_cnt_p1;
  logic [7:0]  run_max_p1;
  logic [7:0]  run_min_p1;
  logic        seen_p1;

  logic [31:0] freq_cnt_p2;
  logic [7:0]  v_max_p2;
  logic [7:0]  v_min_p2;
  logic [7:0]  vpp_p2;
  logic        no_signal_p2;
  logic        vld_p2;

  // Stage p0: combine the current accepted sample with the running values
  logic        acc_p0;
  logic        cross_p0;
  logic        close_p0;
  logic [31:0] edge_nxt_p0;
  logic [7:0]  max_nxt_p0;
  logic [7:0]  min_nxt_p0;
  logic        seen_nxt_p0;

  always_comb begin
    acc_p0      = bus.adc_valid;
    cross_p0    = acc_p0 && (state == WAIT_HIGH) && (bus.adc_data >= THR_HI);
    close_p0    = (gate_cnt == GATE_LAST);
    edge_nxt_p0 = cross_p0 ? sat_inc(edge_cnt_p1) : edge_cnt_p1;
    max_nxt_p0  = run_max_p1;
    min_nxt_p0  = run_min_p1;
    if (acc_p0 && (bus.adc_data > run_max_p1)) max_nxt_p0 = bus.adc_data;
    if (acc_p0 && (bus.adc_data < run_min_p1)) min_nxt_p0 = bus.adc_data;
    seen_nxt_p0 = seen_p1 | acc_p0;
  end

  // Crossing detector; deliberately not cleared at window close so a
  // low-to-high transition straddling a boundary is counted exactly once.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= ARM_LOW;
    end else if (acc_p0) begin
      case (state)
        ARM_LOW:   if (bus.adc_data <= THR_LO) state <= WAIT_HIGH;
        WAIT_HIGH: if (bus.adc_data >= THR_HI) state <= ARM_LOW;
        default:   state <= ARM_LOW;
      endcase
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      gate_cnt <= '0;
    end else if (close_p0) begin
      gate_cnt <= '0;
    end else begin
      gate_cnt <= gate_cnt + GATE_W'(1);
    end
  end

  // Stage p1: running window accumulators
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      edge_cnt_p1 <= '0;
      run_max_p1  <= 8'h00;
      run_min_p1  <= 8'hFF;
      seen_p1     <= 1'b0;
    end else if (close_p0) begin
      edge_cnt_p1 <= '0;
      run_max_p1  <= 8'h00;
      run_min_p1  <= 8'hFF;
      seen_p1     <= 1'b0;
    end else begin
      edge_cnt_p1 <= edge_nxt_p0;
      run_max_p1  <= max_nxt_p0;
      run_min_p1  <= min_nxt_p0;
      seen_p1     <= seen_nxt_p0;
    end
  end

  // Stage p2: results latched at window close, held until the next close
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      freq_cnt_p2  <= '0;
      v_max_p2     <= 8'h00;
      v_min_p2     <= 8'h00;
      vpp_p2       <= 8'h00;
      no_signal_p2 <= 1'b1;
      vld_p2       <= 1'b0;
    end else begin
      vld_p2 <= close_p0;
      if (close_p0) begin
        freq_cnt_p2  <= edge_nxt_p0;
        no_signal_p2 <= (edge_nxt_p0 == 32'd0);
        if (seen_nxt_p0) begin
          v_max_p2 <= max_nxt_p0;
          v_min_p2 <= min_nxt_p0;
          vpp_p2   <= span(max_nxt_p0, min_nxt_p0);
        end else begin
          v_max_p2 <= 8'h00;
          v_min_p2 <= 8'h00;
          vpp_p2   <= 8'h00;
        end
      end
    end
  end

  assign bus.freq_cnt   = freq_cnt_p2;
  assign bus.v_max      = v_max_p2;
  assign bus.v_min      = v_min_p2;
  assign bus.vpp        = vpp_p2;
  assign bus.no_signal  = no_signal_p2;
  assign bus.meas_valid = vld_p2;

endmodule

// File: tb/tb_adc_wave_meter.sv
// Scoreboard bench for adc_wave_meter: stimulus pushes expected window results,
// a negedge monitor pops and compares them on every meas_valid pulse.
module tb_adc_wave_meter;
  localparam int GATE = 1000;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  adc_wave_meter_if bus();

  adc_wave_meter #(
    .GATE_CYCLES(GATE),
    .MID        (8'd128),
    .HYST       (8'd8)
  ) dut (
    .sys_clk(clk),
    .sys_rst(rst),
    .bus    (bus)
  );

  typedef struct packed {
    logic [31:0] cyc;
    logic [31:0] freq;
    logic [7:0]  vmax;
    logic [7:0]  vmin;
    logic [7:0]  vpp;
    logic        nosig;
  } exp_t;

  exp_t sb[$];
  int compared   = 0;
  int mismatched = 0;
  int win        = 0;

  // Cycles since the last reset release; the first pulse is due at 1000.
  logic [31:0] cyc;
  always @(posedge clk or posedge rst)
    if (rst) cyc <= 32'd0;
    else     cyc <= cyc + 32'd1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task automatic expect_win(input logic [31:0] f, input logic [7:0] mx, input logic [7:0] mn,
                            input logic [7:0] vp, input logic ns);
    exp_t e;
    win++;
    e.cyc   = 32'(win * GATE);
    e.freq  = f;
    e.vmax  = mx;
    e.vmin  = mn;
    e.vpp   = vp;
    e.nosig = ns;
    sb.push_back(e);
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    bus.adc_valid = v;
    bus.adc_data  = d;
    @(negedge clk);
  endtask

  task automatic check_reset_values();
    chk("rst_freq_cnt",   bus.freq_cnt,   32'd0);
    chk("rst_v_max",      32'(bus.v_max), 32'd0);
    chk("rst_v_min",      32'(bus.v_min), 32'd0);
    chk("rst_vpp",        32'(bus.vpp),   32'd0);
    chk("rst_no_signal",  32'(bus.no_signal),  32'd1);
    chk("rst_meas_valid", 32'(bus.meas_valid), 32'd0);
  endtask

  function automatic logic [7:0] sq(input int n, input int half);
    return ((n % (2 * half)) < half) ? 8'd0 : 8'd255;
  endfunction

  // Symmetric triangle with period 50 reaching exactly base and base+amp.
  function automatic logic [7:0] tri_wave(input int p, input int base, input int amp);
    int q;
    q = (p < 25) ? p : 49 - p;
    return 8'(base + (q * amp + 12) / 24);
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (bus.meas_valid === 1'b1) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("FAIL unexpected_meas_valid: got pulse at cycle %0d, required none", cyc);
      end else begin
        e = sb.pop_front();
        chk("meas_cycle", cyc,                 e.cyc);
        chk("freq_cnt",   bus.freq_cnt,        e.freq);
        chk("v_max",      32'(bus.v_max),      32'(e.vmax));
        chk("v_min",      32'(bus.v_min),      32'(e.vmin));
        chk("vpp",        32'(bus.vpp),        32'(e.vpp));
        chk("no_signal",  32'(bus.no_signal),  32'(e.nosig));
      end
    end
  end

  initial begin
    bus.adc_valid = 1'b0;
    bus.adc_data  = 8'd0;
    repeat (3) @(negedge clk);
    check_reset_values();
    rst = 1'b0;

    // Square 0/255, period 100, two windows
    expect_win(32'd10, 8'd255, 8'd0, 8'd255, 1'b0);
    expect_win(32'd10, 8'd255, 8'd0, 8'd255, 1'b0);
    for (int i = 0; i < 2 * GATE; i++) drive(1'b1, sq(i, 50));

    // Triangle touching both thresholds, then confined inside the band
    expect_win(32'd20, 8'd136, 8'd120, 8'd16, 1'b0);
    for (int i = 0; i < GATE; i++) drive(1'b1, tri_wave(i % 50, 120, 16));
    expect_win(32'd0, 8'd135, 8'd121, 8'd14, 1'b1);
    for (int i = 0; i < GATE; i++) drive(1'b1, tri_wave(i % 50, 121, 14));

    // No accepted samples for a whole window
    expect_win(32'd0, 8'd0, 8'd0, 8'd0, 1'b1);
    for (int i = 0; i < GATE; i++) drive(1'b0, 8'($urandom));

    // Crossing completed on the closing edge belongs to the closing window
    expect_win(32'd1, 8'd255, 8'd0, 8'd255, 1'b0);
    for (int i = 0; i < GATE; i++)
      drive(1'b1, (i == 998) ? 8'd0 : ((i == 999) ? 8'd255 : 8'd128));
    expect_win(32'd0, 8'd128, 8'd128, 8'd0, 1'b1);
    for (int i = 0; i < GATE; i++) drive(1'b1, 8'd128);

    // Reset in mid-window: partial window dropped, timing restarts at release
    for (int i = 0; i < 500; i++) drive(1'b1, sq(i, 50));
    rst = 1'b1;
    #1;
    check_reset_values();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    win = 0;
    expect_win(32'd10, 8'd255, 8'd0, 8'd255, 1'b0);
    for (int i = 0; i < GATE; i++) drive(1'b1, sq(i, 50));

    // Valid every other cycle; idle cycles carry the opposite level
    expect_win(32'd25, 8'd255, 8'd0, 8'd255, 1'b0);
    for (int i = 0; i < GATE; i++) begin
      if (i % 2 == 0) drive(1'b1, sq(i / 2, 10));
      else            drive(1'b0, ~sq(i / 2, 10));
    end

    repeat (5) drive(1'b0, 8'd0);
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
